memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-port arbiter and sequencer that shares the single-ported `memory` array between the instruction-fetch (IF) and data-memory (DM) stages of the core. Each requester uses a req/ack handshake. The arbiter grants one requester at a time, drives the memory's `memory_as_`/`memory_rw` strobe protocol for exactly one cycle, and returns read data and an error flag. It sits between the pipeline front/back ends and `memory`.

## Interface
- `ARB_MODE`, default 0: 0 = round-robin between IF and DM; 1 = fixed priority, DM always wins.
- `ALIGN_CHECK`, default 1: 1 = reject addresses with `addr[1:0] != 0`; 0 = pass all addresses.

Clock and reset: one clock; reset is asynchronous and active-high.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request, held until `if_ack`.
- `if_addr`  in  30  fetch byte address.
- `if_ack`  out  1  one-cycle completion pulse.
- `if_rdata`  out  32  fetched word, valid with `if_ack`.
- `if_err`  out  1  misaligned fetch, valid with `if_ack`.
- `dm_req`  in  1  data request, held until `dm_ack`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`  in  30  data byte address.
- `dm_wdata`  in  32  store data.
- `dm_ack`  out  1  one-cycle completion pulse.
- `dm_rdata`  out  32  load word, valid with `dm_ack` (0 for stores).
- `dm_err`  out  1  misaligned access, valid with `dm_ack`.
- `memory_addr`  out  30  to memory.
- `memory_as_`  out  1  active-low access strobe.
- `memory_rw`  out  1  1 = READ, 0 = WRITE.
- `memory_wr_data`  out  32  to memory.
- `memory_rd_data`  in  32  combinational read data from memory.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - With no request pending, remain in IDLE.
  - With a request pending, pick a winner:
    - `ARB_MODE=0` (round-robin): when both request, the winner is the port not recorded in `last_grant`; a single requester always wins.
    - `ARB_MODE=1` (fixed): DM wins whenever `dm_req` is high.
  - Latch the winner's addr, we (always 0 for IF) and wdata into registers, and update `last_grant`.
  - If `ALIGN_CHECK=1` and the latched `addr[1:0] != 0`: set the err flag and go to RESP with no memory access.
  - Otherwise go to ACCESS.
- **ACCESS**
  - Drive `memory_as_=0`, `memory_addr` = latched address, `memory_rw` = ~we, `memory_wr_data` = latched wdata.
  - On a read, capture `memory_rd_data` into the response register at the end of the cycle.
  - A store commits at the same clock edge.
  - Always go to RESP.
- **RESP**
  - Pulse the granted port's ack for one cycle with its rdata and err; the other port's ack stays 0.
  - Response data is held until the next response to that port.
  - Always go to IDLE.
- **Reset values**
  - Port side: all acks and errs 0, rdatas 0, `busy` 0.
  - Memory side: `memory_as_=1`, `memory_rw=1`, `memory_addr=0`, `memory_wr_data=0`.
  - `last_grant` = DM, so IF wins the first tie.
- **Requester rules**
  - Address, we and wdata must stay stable from req until ack. The arbiter ignores changes after the latch, but the requirement is part of the contract.
  - A request held high in the ack cycle is treated as a new request in the following IDLE.
- **Reset mid-operation:** asserting `rst` during ACCESS, before the commit edge, aborts the access. No write occurs and no ack is issued; all outputs return to reset values immediately.

## Timing
- Request seen high at edge N in IDLE → ACCESS during cycle N+1 (`memory_as_` low for exactly one cycle) → ack high during cycle N+2 → IDLE at N+3.
- Occupancy: 3 cycles per access; 2 cycles per misaligned (error) access.
- Maximum throughput: one access per 3 cycles.
- Round-robin starvation bound: with both ports requesting continuously, grants strictly alternate. The worst-case wait is one foreign access, i.e. ack within 6 cycles of the request.
- `memory_as_` is never low outside ACCESS.
- All outputs are registered.

## Test plan
- **Reset:** assert `rst` with random inputs → `memory_as_=1`, `memory_rw=1`, both acks 0, `busy=0`.
- **Single fetch:** preload memory[0x100..0x103] = 11,22,33,44; `if_req`, `if_addr=0x100` → `memory_as_` low one cycle with `memory_rw=1`; `if_ack` two cycles after the request with `if_rdata=0x11223344`, `if_err=0`.
- **Store then load:** `dm_we=1`, `dm_addr=0x40`, `dm_wdata=0xDEADBEEF`, then a load from 0x40 → `dm_rdata=0xDEADBEEF`; the store's `dm_rdata=0`.
- **Contention:**
  - `ARB_MODE=0`, both ports requesting continuously from reset → grant order IF, DM, IF, DM; each ack within 6 cycles.
  - `ARB_MODE=1`, same stimulus → DM granted every time.
- **Misalignment:** `dm_addr=0x41`, `ALIGN_CHECK=1` → `dm_ack` with `dm_err=1` one cycle after the request, `memory_as_` never low, memory unchanged. With `ALIGN_CHECK=0` the access proceeds normally.
- **Reset mid-access:** a store to 0x80 with `rst` pulsed during ACCESS → memory[0x80] unchanged, no `dm_ack`, FSM in IDLE.

Source files
------------

// File: rtl/memory_arbiter.sv
// Arbiter/sequencer sharing one single-ported memory between instruction fetch and data access.
// Runs an IDLE -> ACCESS -> RESP cycle per grant; every output comes straight from a register.
module memory_arbiter #(
  parameter int unsigned ARB_MODE    = 0,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [29:0] i_if_addr,
  output logic        o_if_ack,
  output logic [31:0] o_if_rdata,
  output logic        o_if_err,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [29:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  output logic        o_dm_ack,
  output logic [31:0] o_dm_rdata,
  output logic        o_dm_err,
  output logic [29:0] o_memory_addr,
  output logic        o_memory_as_,
  output logic        o_memory_rw,
  output logic [31:0] o_memory_wr_data,
  input  logic [31:0] i_memory_rd_data,
  output logic        o_busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      r_state, w_state_d;
  logic        r_last_dm, w_last_dm_d;
  logic        r_grant_dm, w_grant_dm_d;
  logic        r_we, w_we_d;
  logic        r_if_ack, w_if_ack_d, r_dm_ack, w_dm_ack_d;
  logic        r_if_err, w_if_err_d, r_dm_err, w_dm_err_d;
  logic [31:0] r_if_rdata, w_if_rdata_d, r_dm_rdata, w_dm_rdata_d;
  logic [29:0] r_mem_addr, w_mem_addr_d;
  logic        r_mem_as_n, w_mem_as_n_d, r_mem_rw, w_mem_rw_d;
  logic [31:0] r_mem_wr_data, w_mem_wr_data_d;
  logic        r_busy, w_busy_d;
  logic        w_pick_dm, w_misalign;
  logic [29:0] w_sel_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_last_dm     <= 1'b1;  // IF wins the first tie
      r_grant_dm    <= 1'b0;
      r_we          <= 1'b0;
      r_if_ack      <= 1'b0;
      r_dm_ack      <= 1'b0;
      r_if_err      <= 1'b0;
      r_dm_err      <= 1'b0;
      r_if_rdata    <= '0;
      r_dm_rdata    <= '0;
      r_mem_addr    <= '0;
      r_mem_as_n    <= 1'b1;
      r_mem_rw      <= 1'b1;
      r_mem_wr_data <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_last_dm     <= w_last_dm_d;
      r_grant_dm    <= w_grant_dm_d;
      r_we          <= w_we_d;
      r_if_ack      <= w_if_ack_d;
      r_dm_ack      <= w_dm_ack_d;
      r_if_err      <= w_if_err_d;
      r_dm_err      <= w_dm_err_d;
      r_if_rdata    <= w_if_rdata_d;
      r_dm_rdata    <= w_dm_rdata_d;
      r_mem_addr    <= w_mem_addr_d;
      r_mem_as_n    <= w_mem_as_n_d;
      r_mem_rw      <= w_mem_rw_d;
      r_mem_wr_data <= w_mem_wr_data_d;
      r_busy        <= w_busy_d;
    end
  end

  always_comb begin
    w_pick_dm  = (ARB_MODE == 1) ? i_dm_req : (i_dm_req && (!i_if_req || !r_last_dm));
    w_sel_addr = w_pick_dm ? i_dm_addr : i_if_addr;
    w_misalign = (ALIGN_CHECK != 0) && (w_sel_addr[1:0] != 2'b00);

    w_state_d       = r_state;
    w_last_dm_d     = r_last_dm;
    w_grant_dm_d    = r_grant_dm;
    w_we_d          = r_we;
    w_if_ack_d      = 1'b0;
    w_dm_ack_d      = 1'b0;
    w_if_err_d      = r_if_err;
    w_dm_err_d      = r_dm_err;
    w_if_rdata_d    = r_if_rdata;
    w_dm_rdata_d    = r_dm_rdata;
    w_mem_addr_d    = r_mem_addr;
    w_mem_as_n_d    = 1'b1;
    w_mem_rw_d      = 1'b1;
    w_mem_wr_data_d = r_mem_wr_data;

    unique case (r_state)
      StIdle: begin
        if (i_if_req || i_dm_req) begin
          w_grant_dm_d    = w_pick_dm;
          w_last_dm_d     = w_pick_dm;
          w_we_d          = w_pick_dm & i_dm_we;
          w_mem_addr_d    = w_sel_addr;
          w_mem_wr_data_d = w_pick_dm ? i_dm_wdata : 32'h0;
          if (w_misalign) begin
            // Error response goes out directly, skipping the memory cycle
            w_state_d = StResp;
            if (w_pick_dm) begin
              w_dm_ack_d   = 1'b1;
              w_dm_err_d   = 1'b1;
              w_dm_rdata_d = 32'h0;
            end else begin
              w_if_ack_d   = 1'b1;
              w_if_err_d   = 1'b1;
              w_if_rdata_d = 32'h0;
            end
          end else begin
            w_state_d    = StAccess;
            w_mem_as_n_d = 1'b0;
            w_mem_rw_d   = ~(w_pick_dm & i_dm_we);
          end
        end
      end
      StAccess: begin
        w_state_d = StResp;
        if (r_grant_dm) begin
          w_dm_ack_d   = 1'b1;
          w_dm_err_d   = 1'b0;
          w_dm_rdata_d = r_we ? 32'h0 : i_memory_rd_data;
        end else begin
          w_if_ack_d   = 1'b1;
          w_if_err_d   = 1'b0;
          w_if_rdata_d = i_memory_rd_data;
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    w_busy_d = (w_state_d != StIdle);
  end

  assign o_if_ack         = r_if_ack;
  assign o_if_rdata       = r_if_rdata;
  assign o_if_err         = r_if_err;
  assign o_dm_ack         = r_dm_ack;
  assign o_dm_rdata       = r_dm_rdata;
  assign o_dm_err         = r_dm_err;
  assign o_memory_addr    = r_mem_addr;
  assign o_memory_as_     = r_mem_as_n;
  assign o_memory_rw      = r_mem_rw;
  assign o_memory_wr_data = r_mem_wr_data;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: three instances (round-robin, fixed priority, no align check),
// each with its own byte-addressed big-endian memory model.
module tb_memory_arbiter;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req [NI];
  logic        dm_req [NI];
  logic [29:0] if_addr, dm_addr;
  logic        dm_we;
  logic [31:0] dm_wdata;
  logic        if_ack [NI], if_err [NI], dm_ack [NI], dm_err [NI];
  logic [31:0] if_rdata [NI], dm_rdata [NI];
  logic [29:0] mem_addr [NI];
  logic        mem_as_n [NI], mem_rw [NI], busy [NI];
  logic [31:0] mem_wr_data [NI], mem_rd_data [NI];
  logic [7:0]  mem [NI][1024];

  int          n_tests = 0;
  int          n_fail = 0;

  int          lat [NI], as_lo [NI], other_ack [NI];
  logic [31:0] rdat [NI];
  logic        err_r [NI], rw_acc [NI];
  logic [29:0] addr_acc [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [9:0] a;
    assign a = mem_addr[g][9:0];
    assign mem_rd_data[g] = {mem[g][a], mem[g][a + 10'd1], mem[g][a + 10'd2], mem[g][a + 10'd3]};

    memory_arbiter #(
      .ARB_MODE   ((g == 1) ? 1 : 0),
      .ALIGN_CHECK((g == 2) ? 0 : 1)
    ) u_dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_if_req        (if_req[g]),
      .i_if_addr       (if_addr),
      .o_if_ack        (if_ack[g]),
      .o_if_rdata      (if_rdata[g]),
      .o_if_err        (if_err[g]),
      .i_dm_req        (dm_req[g]),
      .i_dm_we         (dm_we),
      .i_dm_addr       (dm_addr),
      .i_dm_wdata      (dm_wdata),
      .o_dm_ack        (dm_ack[g]),
      .o_dm_rdata      (dm_rdata[g]),
      .o_dm_err        (dm_err[g]),
      .o_memory_addr   (mem_addr[g]),
      .o_memory_as_    (mem_as_n[g]),
      .o_memory_rw     (mem_rw[g]),
      .o_memory_wr_data(mem_wr_data[g]),
      .i_memory_rd_data(mem_rd_data[g]),
      .o_busy          (busy[g])
    );
  end

  // Memory commits a store on the clock edge that ends the strobe cycle
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (!mem_as_n[g] && !mem_rw[g]) begin
        mem[g][mem_addr[g][9:0]]         = mem_wr_data[g][31:24];
        mem[g][mem_addr[g][9:0] + 10'd1] = mem_wr_data[g][23:16];
        mem[g][mem_addr[g][9:0] + 10'd2] = mem_wr_data[g][15:8];
        mem[g][mem_addr[g][9:0] + 10'd3] = mem_wr_data[g][7:0];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on every instance; records ack latency, response and strobe activity
  task automatic xact(input bit dm, input bit we, input logic [29:0] addr, input logic [31:0] wd);
    if_addr  = addr;
    dm_addr  = addr;
    dm_we    = we;
    dm_wdata = wd;
    for (int g = 0; g < NI; g++) begin
      lat[g] = 0; as_lo[g] = 0; other_ack[g] = 0; rdat[g] = 'x; err_r[g] = 1'bx;
      rw_acc[g] = 1'bx; addr_acc[g] = 'x;
      if_req[g] = !dm;
      dm_req[g] = dm;
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      for (int g = 0; g < NI; g++) begin
        if (!mem_as_n[g]) begin
          as_lo[g]++;
          rw_acc[g]   = mem_rw[g];
          addr_acc[g] = mem_addr[g];
        end
        if ((dm ? dm_ack[g] : if_ack[g]) && lat[g] == 0) begin
          lat[g]    = c;
          rdat[g]   = dm ? dm_rdata[g] : if_rdata[g];
          err_r[g]  = dm ? dm_err[g] : if_err[g];
          if_req[g] = 1'b0;
          dm_req[g] = 1'b0;
        end
        if (dm ? if_ack[g] : dm_ack[g]) other_ack[g]++;
      end
    end
  endtask

  int ord [NI][4];
  int nack [NI], n_if_ack [NI], last_if [NI], last_dm [NI], max_gap [NI];
  int dm_seen;

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    if_addr  = 30'($urandom);
    dm_addr  = 30'($urandom);
    dm_we    = 1'($urandom);
    dm_wdata = $urandom;
    for (int g = 0; g < NI; g++) begin
      if_req[g] = 1'($urandom);
      dm_req[g] = 1'($urandom);
      for (int i = 0; i < 1024; i++) mem[g][i] = 8'h00;
      mem[g][10'h100] = 8'h11; mem[g][10'h101] = 8'h22;
      mem[g][10'h102] = 8'h33; mem[g][10'h103] = 8'h44;
      for (int i = 0; i < 4; i++) mem[g][10'h080 + i] = 8'h55;
    end
    repeat (2) tick();
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst_as[%0d]", g), 32'(mem_as_n[g]), 32'd1);
      check($sformatf("rst_rw[%0d]", g), 32'(mem_rw[g]), 32'd1);
      check($sformatf("rst_acks[%0d]", g), {30'd0, if_ack[g], dm_ack[g]}, 32'd0);
      check($sformatf("rst_busy[%0d]", g), 32'(busy[g]), 32'd0);
      check($sformatf("rst_addr[%0d]", g), 32'(mem_addr[g]), 32'd0);
      check($sformatf("rst_wdata[%0d]", g), mem_wr_data[g], 32'd0);
      check($sformatf("rst_rdata[%0d]", g), if_rdata[g] | dm_rdata[g], 32'd0);
      if_req[g] = 1'b0;
      dm_req[g] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;

    // Single fetch
    xact(1'b0, 1'b0, 30'h100, 32'h0);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("fetch_lat[%0d]", g), 32'(lat[g]), 32'd2);
      check($sformatf("fetch_data[%0d]", g), rdat[g], 32'h11223344);
      check($sformatf("fetch_err[%0d]", g), 32'(err_r[g]), 32'd0);
      check($sformatf("fetch_strobe[%0d]", g), 32'(as_lo[g]), 32'd1);
      check($sformatf("fetch_rw[%0d]", g), 32'(rw_acc[g]), 32'd1);
      check($sformatf("fetch_addr[%0d]", g), 32'(addr_acc[g]), 32'h100);
      check($sformatf("fetch_dmack[%0d]", g), 32'(other_ack[g]), 32'd0);
      check($sformatf("fetch_idle[%0d]", g), 32'(busy[g]), 32'd0);
    end

    // Store then load
    xact(1'b1, 1'b1, 30'h40, 32'hDEADBEEF);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("st_lat[%0d]", g), 32'(lat[g]), 32'd2);
      check($sformatf("st_rdata[%0d]", g), rdat[g], 32'h0);
      check($sformatf("st_rw[%0d]", g), 32'(rw_acc[g]), 32'd0);
      check($sformatf("st_mem[%0d]", g), {mem[g][10'h40], mem[g][10'h41], mem[g][10'h42],
                                          mem[g][10'h43]}, 32'hDEADBEEF);
    end
    xact(1'b1, 1'b0, 30'h40, 32'h0);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("ld_lat[%0d]", g), 32'(lat[g]), 32'd2);
      check($sformatf("ld_data[%0d]", g), rdat[g], 32'hDEADBEEF);
      check($sformatf("ld_err[%0d]", g), 32'(err_r[g]), 32'd0);
    end

    // Misaligned store: rejected on instances 0/1, performed on instance 2
    xact(1'b1, 1'b1, 30'h41, 32'hCAFEF00D);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("mis_lat[%0d]", g), 32'(lat[g]), 32'd1);
      check($sformatf("mis_err[%0d]", g), 32'(err_r[g]), 32'd1);
      check($sformatf("mis_strobe[%0d]", g), 32'(as_lo[g]), 32'd0);
      check($sformatf("mis_mem[%0d]", g), {mem[g][10'h41], mem[g][10'h42], mem[g][10'h43],
                                           mem[g][10'h44]}, 32'hADBEEF00);
    end
    check("noalign_lat", 32'(lat[2]), 32'd2);
    check("noalign_err", 32'(err_r[2]), 32'd0);
    check("noalign_strobe", 32'(as_lo[2]), 32'd1);
    check("noalign_mem", {mem[2][10'h41], mem[2][10'h42], mem[2][10'h43], mem[2][10'h44]},
          32'hCAFEF00D);

    // Contention from reset
    tick();
    rst      = 1'b1;
    if_addr  = 30'h100;
    dm_addr  = 30'h40;
    dm_we    = 1'b0;
    for (int g = 0; g < NI; g++) begin
      if_req[g] = 1'b1; dm_req[g] = 1'b1;
      nack[g] = 0; n_if_ack[g] = 0; last_if[g] = 0; last_dm[g] = 0; max_gap[g] = 0;
      for (int k = 0; k < 4; k++) ord[g][k] = 9;
    end
    #2 rst = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      for (int g = 0; g < NI; g++) begin
        if (if_ack[g]) begin
          if (nack[g] < 4) ord[g][nack[g]] = 0;
          nack[g]++; n_if_ack[g]++;
          if (c - last_if[g] > max_gap[g]) max_gap[g] = c - last_if[g];
          last_if[g] = c;
        end
        if (dm_ack[g]) begin
          if (nack[g] < 4) ord[g][nack[g]] = 1;
          nack[g]++;
          if (c - last_dm[g] > max_gap[g]) max_gap[g] = c - last_dm[g];
          last_dm[g] = c;
        end
      end
    end
    for (int g = 0; g < NI; g++) begin
      if_req[g] = 1'b0; dm_req[g] = 1'b0;
    end
    for (int g = 0; g < NI; g += 2) begin
      check($sformatf("rr_order[%0d]", g), {ord[g][0][7:0], ord[g][1][7:0], ord[g][2][7:0],
                                            ord[g][3][7:0]}, 32'h00010001);
      check($sformatf("rr_wait_le6[%0d]", g), 32'(max_gap[g] <= 6), 32'd1);
      check($sformatf("rr_acks[%0d]", g), 32'(nack[g]), 32'd8);
    end
    check("fixed_order", {ord[1][0][7:0], ord[1][1][7:0], ord[1][2][7:0], ord[1][3][7:0]},
          32'h01010101);
    check("fixed_if_acks", 32'(n_if_ack[1]), 32'd0);
    repeat (4) tick();

    // Reset in the middle of an access: store must not commit
    dm_addr  = 30'h80;
    dm_we    = 1'b1;
    dm_wdata = 32'h12345678;
    for (int g = 0; g < NI; g++) dm_req[g] = 1'b1;
    tick();
    check("abort_in_access", {31'd0, mem_as_n[0]}, 32'd0);
    #1 rst = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("abort_as[%0d]", g), 32'(mem_as_n[g]), 32'd1);
      check($sformatf("abort_busy[%0d]", g), 32'(busy[g]), 32'd0);
      dm_req[g] = 1'b0;
    end
    #1 rst = 1'b0;
    dm_seen = 0;
    repeat (5) begin
      tick();
      for (int g = 0; g < NI; g++) if (dm_ack[g]) dm_seen++;
    end
    check("abort_no_ack", 32'(dm_seen), 32'd0);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("abort_mem[%0d]", g), {mem[g][10'h80], mem[g][10'h81], mem[g][10'h82],
                                             mem[g][10'h83]}, 32'h55555555);
      check($sformatf("abort_idle[%0d]", g), 32'(busy[g]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
